// File: rtl/seq_mod_reduce_pkg.sv
// Shared types and elaboration helpers for the sequential modular reducer.
package seq_mod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Number of DIG_W-bit digits covering an IN_W-bit operand.
  function automatic int unsigned ndig(input int unsigned in_w, input int unsigned dig_w);
    return (in_w + dig_w - 1) / dig_w;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_mod_reduce_digit_step.sv
// One Horner step: acc_next = ((acc << DIG_W) | d) mod m, by a DIG_W-stage restoring subtract.
module mod_digit_step #(
  parameter int unsigned M_W   = 7,
  parameter int unsigned DIG_W = 4
) (
  input  logic [M_W-1:0]   acc,
  input  logic [DIG_W-1:0] d,
  input  logic [M_W-1:0]   m,
  output logic [M_W-1:0]   acc_next
);

  logic [M_W+DIG_W-1:0] t;
  logic [M_W+DIG_W-1:0] ms;

  // With acc < m the partial value is below m<<DIG_W, so one conditional
  // subtract per bit position leaves t < m. m == 0 inhibits the chain.
  always_comb begin
    t  = {acc, d};
    ms = '0;
    for (int unsigned k = 0; k < DIG_W; k++) begin
      ms = {{DIG_W{1'b0}}, m} << (DIG_W - 1 - k);
      if ((m != '0) && (t >= ms)) t = t - ms;
    end
    acc_next = t[M_W-1:0];
  end

endmodule

// File: rtl/seq_mod_reduce.sv
// Iterative X mod M reducer: one DIG_W-bit digit per cycle, MSB digit first, valid/ready on both sides.
module seq_mod_reduce
  import seq_mod_pkg::*;
#(
  parameter int unsigned IN_W  = 300,
  parameter int unsigned M_W   = 7,
  parameter int unsigned DIG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] X,
  input  logic [M_W-1:0]  M,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M_W-1:0]  R,
  output logic            err
);

  localparam int unsigned NDIG  = ndig(IN_W, DIG_W);
  localparam int unsigned PAD_W = NDIG * DIG_W;
  localparam int unsigned CNT_W = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

  state_e             state_q, state_d;
  logic [PAD_W-1:0]   sh_q, sh_d;
  logic [M_W-1:0]     acc_q, acc_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [M_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               eout_q, eout_d;
  logic [M_W-1:0]     acc_step;
  logic               accept;

  mod_digit_step #(
    .M_W   (M_W),
    .DIG_W (DIG_W)
  ) u_step (
    .acc      (acc_q),
    .d        (sh_q[PAD_W-1 -: DIG_W]),
    .m        (m_q),
    .acc_next (acc_step)
  );

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign R         = r_q;
  assign err       = eout_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    eout_d  = eout_q;
    case (state_q)
      RUN: begin
        sh_d  = sh_q << DIG_W;
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          r_d     = err_q ? '0 : acc_step;
          eout_d  = err_q;
          state_d = DONE;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A load from DONE overrides the return to IDLE on the output handshake edge.
    if (accept) begin
      sh_d    = PAD_W'(X);
      m_d     = M;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = (M == '0);
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      eout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      eout_q  <= eout_d;
    end
  end

endmodule

// File: tb/tb_seq_mod_reduce.sv
// Scoreboard bench for seq_mod_reduce: driver pushes expectations, negedge monitor pops on handshake.
module tb_seq_mod_reduce;

  localparam int unsigned IN_W  = 300;
  localparam int unsigned M_W   = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned NDIG  = 75;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] X = '0;
  logic [M_W-1:0]  M = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [M_W-1:0]  R;
  logic            err;

  seq_mod_reduce #(
    .IN_W  (IN_W),
    .M_W   (M_W),
    .DIG_W (DIG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .M         (M),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M_W-1:0] r;
    logic           e;
    int             acc_cyc;
  } exp_t;

  typedef struct {
    logic [IN_W-1:0] x;
    logic [M_W-1:0]  m;
    logic [M_W-1:0]  r;
    logic            e;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) chk("latency_noexp", 64'd1, 64'd0);
      else chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(NDIG));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("R", 64'(R), 64'(e.r));
        chk("err", 64'(err), 64'(e.e));
      end
    end
    ov_prev <= out_valid;
  end

  task automatic send(input logic [IN_W-1:0] x, input logic [M_W-1:0] m,
                      input logic [M_W-1:0] r, input logic e);
    exp_t ex;
    bit   done;
    done = 0;
    @(posedge clk) #1;
    in_valid = 1'b1;
    X = x;
    M = m;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ex.r = r;
        ex.e = e;
        ex.acc_cyc = cyc + 1;
        sb.push_back(ex);
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk) #1;
  endtask

  vec_t vecs[10];
  logic [IN_W-1:0] xr, rfull;
  logic [M_W-1:0]  mr;
  bit              seen;

  initial begin
    vecs[0] = '{x: 300'd1000,    m: 7'd107, r: 7'd37,  e: 1'b0};
    vecs[1] = '{x: 300'd16384,   m: 7'd107, r: 7'd13,  e: 1'b0};
    vecs[2] = '{x: 300'd107,     m: 7'd107, r: 7'd0,   e: 1'b0};
    vecs[3] = '{x: 300'd106,     m: 7'd107, r: 7'd106, e: 1'b0};
    vecs[4] = '{x: 300'd1000,    m: 7'd3,   r: 7'd1,   e: 1'b0};
    vecs[5] = '{x: {IN_W{1'b1}}, m: 7'd1,   r: 7'd0,   e: 1'b0};
    vecs[6] = '{x: {IN_W{1'b1}}, m: 7'd127, r: 7'd63,  e: 1'b0};
    vecs[7] = '{x: 300'd5,       m: 7'd0,   r: 7'd0,   e: 1'b1};
    vecs[8] = '{x: 300'd638,     m: 7'd127, r: 7'd3,   e: 1'b0};
    vecs[9] = '{x: 300'd0,       m: 7'd107, r: 7'd0,   e: 1'b0};

    // reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_R", 64'(R), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    // directed vectors, one at a time
    foreach (vecs[i]) begin
      send(vecs[i].x, vecs[i].m, vecs[i].r, vecs[i].e);
      drain();
    end

    // back-pressure in DONE, then handshake and new accept on the same edge
    out_ready = 1'b0;
    send(vecs[0].x, vecs[0].m, vecs[0].r, vecs[0].e);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_R", 64'(R), 64'(vecs[0].r));
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    X = vecs[1].x;
    M = vecs[1].m;
    @(negedge clk);
    chk("nobubble_in_ready", 64'(in_ready), 64'd1);
    begin
      exp_t ex;
      ex.r = vecs[1].r;
      ex.e = vecs[1].e;
      ex.acc_cyc = cyc + 1;
      sb.push_back(ex);
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
    chk("nobubble_run_out_valid", 64'(out_valid), 64'd0);
    chk("nobubble_run_in_ready", 64'(in_ready), 64'd0);
    drain();

    // reset mid-job at cnt=40
    send(vecs[0].x, vecs[0].m, vecs[0].r, vecs[0].e);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    #1 chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (80) begin
      @(negedge clk);
      if (out_valid) chk("midrst_no_result", 64'd1, 64'd0);
    end
    send(vecs[3].x, vecs[3].m, vecs[3].r, vecs[3].e);
    drain();

    // random operands against a division-based golden model
    for (int n = 0; n < 150; n++) begin
      xr = '0;
      for (int unsigned w = 0; w < 10; w++) xr = {xr[IN_W-33:0], 32'($urandom())};
      if (n % 5 == 0) xr = xr >> $urandom_range(0, 299);
      mr = 7'($urandom_range(1, 127));
      rfull = xr % IN_W'(mr);
      send(xr, mr, rfull[M_W-1:0], 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
